imem_boot_loader: RTL and testbench

//  Boot sequencer for the pipelined core's instruction BRAM. Receives a framed program over a byte stream
//  (e.g. UART RX) and writes it word-by-word through the InstrWrite/WriteInst/WriteAdress port.

---
 rtl/imem_boot_loader.sv | 167 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a framed program over a byte stream and writes it into the instruction BRAM.
// Optional trailing XOR checksum byte is enabled by defining IMEM_BOOT_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  MAGIC     = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        boot_req,
  output logic        core_reset,
  output logic        InstrWrite,
  output logic [31:0] WriteInst,
  output logic [31:0] WriteAdress,
  output logic        boot_done,
  output logic        boot_err,
  output logic [15:0] word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_LAST,
`ifdef IMEM_BOOT_CHECKSUM_EN
    S_CHK,
`endif
    S_RUN,
    S_ERROR
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [7:0]  lenLo;
  logic [15:0] lenWords;
  logic [1:0]  byteIdx;
  logic [23:0] lanes;
  logic [15:0] wordCnt;
  logic [15:0] rxLen;
  logic        lenTooBig;
  logic        lastWord;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]  chkAcc;
`endif

  assign rxLen      = {rx_data, lenLo};
  assign lenTooBig  = {16'b0, rxLen} > MAX_WORDS;
  assign lastWord   = (wordCnt + 16'd1) == lenWords;

  assign core_reset = (state != S_RUN);
  assign boot_done  = (state == S_RUN);
  assign boot_err   = (state == S_ERROR);
  assign word_cnt   = wordCnt;

  // S_LAST delays the release of core_reset by one cycle after the final InstrWrite.
  always_comb begin
    stateNext = state;
    if (boot_req) begin
      stateNext = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (rx_valid && rx_data == MAGIC) stateNext = S_LEN0;
        S_LEN0: if (rx_valid) stateNext = S_LEN1;
        S_LEN1: begin
          if (rx_valid) begin
            if (rxLen == 16'd0) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
              stateNext = S_CHK;
`else
              stateNext = S_RUN;
`endif
            end else if (lenTooBig) begin
              stateNext = S_ERROR;
            end else begin
              stateNext = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (rx_valid && byteIdx == 2'd3 && lastWord) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            stateNext = S_CHK;
`else
            stateNext = S_LAST;
`endif
          end
        end
        S_LAST: stateNext = S_RUN;
`ifdef IMEM_BOOT_CHECKSUM_EN
        S_CHK: begin
          if (rx_valid) stateNext = (rx_data == chkAcc) ? S_RUN : S_ERROR;
        end
`endif
        S_RUN:   stateNext = S_RUN;
        S_ERROR: stateNext = S_ERROR;
        default: stateNext = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      InstrWrite  <= 1'b0;
      WriteInst   <= '0;
      WriteAdress <= BASE_ADDR;
      wordCnt     <= '0;
      byteIdx     <= '0;
      lanes       <= '0;
      lenLo       <= '0;
      lenWords    <= '0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      chkAcc      <= '0;
`endif
    end else begin
      state      <= stateNext;
      InstrWrite <= 1'b0;
      if (boot_req) begin
        wordCnt <= '0;
        byteIdx <= '0;
        lanes   <= '0;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            if (rx_data == MAGIC) chkAcc <= '0;
`endif
          end
          S_LEN0: begin
            lenLo <= rx_data;
`ifdef IMEM_BOOT_CHECKSUM_EN
            chkAcc <= chkAcc ^ rx_data;
`endif
          end
          S_LEN1: begin
            lenWords <= rxLen;
`ifdef IMEM_BOOT_CHECKSUM_EN
            chkAcc <= chkAcc ^ rx_data;
`endif
          end
          S_DATA: begin
`ifdef IMEM_BOOT_CHECKSUM_EN
            chkAcc <= chkAcc ^ rx_data;
`endif
            byteIdx <= byteIdx + 2'd1;
            case (byteIdx)
              2'd0: lanes[7:0]   <= rx_data;
              2'd1: lanes[15:8]  <= rx_data;
              2'd2: lanes[23:16] <= rx_data;
              default: begin
                InstrWrite  <= 1'b1;
                WriteInst   <= {rx_data, lanes};
                WriteAdress <= BASE_ADDR + {14'b0, wordCnt, 2'b00};
                wordCnt     <= wordCnt + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed self-checking bench for imem_boot_loader: framing, write timing, length limits, boot_req and reset.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        boot_req;
  logic        core_reset;
  logic        InstrWrite;
  logic [31:0] WriteInst;
  logic [31:0] WriteAdress;
  logic        boot_done;
  logic        boot_err;
  logic [15:0] word_cnt;

  int unsigned cmpCnt = 0;
  int unsigned errCnt = 0;
  int unsigned pulseCnt = 0;

  imem_boot_loader #(.MAX_WORDS(256), .BASE_ADDR(32'h0), .MAGIC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .boot_req(boot_req),
    .core_reset(core_reset), .InstrWrite(InstrWrite), .WriteInst(WriteInst),
    .WriteAdress(WriteAdress), .boot_done(boot_done), .boot_err(boot_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (InstrWrite === 1'b1) pulseCnt++;

  // Drives one byte at a negedge; returns at the following negedge, after the DUT has taken it.
  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulseBootReq(input logic withByte, input logic [7:0] b);
    boot_req = 1'b1;
    rx_valid = withByte;
    rx_data  = b;
    @(negedge clk);
    boot_req = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic sendTwoWordFrame();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h13); sendByte(8'h05); sendByte(8'hA0); sendByte(8'h00);
    sendByte(8'h93); sendByte(8'h05); sendByte(8'hB0); sendByte(8'h00);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmpCnt++; if (core_reset !== 1'b1) begin errCnt++; $display("FAIL reset_core_reset: got %b expected 1", core_reset); end
    cmpCnt++; if (InstrWrite !== 1'b0) begin errCnt++; $display("FAIL reset_InstrWrite: got %b expected 0", InstrWrite); end
    cmpCnt++; if (boot_done !== 1'b0) begin errCnt++; $display("FAIL reset_boot_done: got %b expected 0", boot_done); end
    cmpCnt++; if (WriteAdress !== 32'h0) begin errCnt++; $display("FAIL reset_WriteAdress: got %h expected 00000000", WriteAdress); end
    cmpCnt++; if (boot_err !== 1'b0 || word_cnt !== 16'd0) begin errCnt++; $display("FAIL reset_err_cnt: got %b/%0d expected 0/0", boot_err, word_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_two_word();
    int unsigned p0 = pulseCnt;
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h13); sendByte(8'h05); sendByte(8'hA0);
    cmpCnt++; if (InstrWrite !== 1'b0) begin errCnt++; $display("FAIL w0_early_write: got %b expected 0", InstrWrite); end
    sendByte(8'h00);
    cmpCnt++; if (InstrWrite !== 1'b1) begin errCnt++; $display("FAIL w0_strobe: got %b expected 1", InstrWrite); end
    cmpCnt++; if (WriteInst !== 32'h00A00513) begin errCnt++; $display("FAIL w0_data: got %h expected 00a00513", WriteInst); end
    cmpCnt++; if (WriteAdress !== 32'h0) begin errCnt++; $display("FAIL w0_addr: got %h expected 00000000", WriteAdress); end
    cmpCnt++; if (word_cnt !== 16'd1) begin errCnt++; $display("FAIL w0_cnt: got %0d expected 1", word_cnt); end
    sendByte(8'h93); sendByte(8'h05); sendByte(8'hB0);
    cmpCnt++; if (InstrWrite !== 1'b0) begin errCnt++; $display("FAIL w1_early_write: got %b expected 0", InstrWrite); end
    sendByte(8'h00);
    cmpCnt++; if (InstrWrite !== 1'b1) begin errCnt++; $display("FAIL w1_strobe: got %b expected 1", InstrWrite); end
    cmpCnt++; if (WriteInst !== 32'h00B00593) begin errCnt++; $display("FAIL w1_data: got %h expected 00b00593", WriteInst); end
    cmpCnt++; if (WriteAdress !== 32'h4) begin errCnt++; $display("FAIL w1_addr: got %h expected 00000004", WriteAdress); end
    cmpCnt++; if (core_reset !== 1'b1) begin errCnt++; $display("FAIL w1_core_reset_held: got %b expected 1", core_reset); end
`ifdef IMEM_BOOT_CHECKSUM_EN
    sendByte(8'h92);
`else
    @(negedge clk);
`endif
    cmpCnt++; if (InstrWrite !== 1'b0) begin errCnt++; $display("FAIL two_strobe_end: got %b expected 0", InstrWrite); end
    cmpCnt++; if (core_reset !== 1'b0) begin errCnt++; $display("FAIL two_core_reset: got %b expected 0", core_reset); end
    cmpCnt++; if (boot_done !== 1'b1) begin errCnt++; $display("FAIL two_boot_done: got %b expected 1", boot_done); end
    cmpCnt++; if (pulseCnt - p0 !== 2) begin errCnt++; $display("FAIL two_pulses: got %0d expected 2", pulseCnt - p0); end
  endtask

  task automatic test_zero_len();
    int unsigned p0;
    pulseBootReq(1'b0, 8'h00);
    cmpCnt++; if (boot_done !== 1'b0 || core_reset !== 1'b1) begin errCnt++; $display("FAIL bootreq_from_run: got done=%b crst=%b expected 0/1", boot_done, core_reset); end
    cmpCnt++; if (word_cnt !== 16'd0) begin errCnt++; $display("FAIL bootreq_cnt: got %0d expected 0", word_cnt); end
    p0 = pulseCnt;
    sendByte(8'h00); sendByte(8'hFF); sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
`ifdef IMEM_BOOT_CHECKSUM_EN
    sendByte(8'h00);
`endif
    cmpCnt++; if (boot_done !== 1'b1 || core_reset !== 1'b0) begin errCnt++; $display("FAIL zero_run: got done=%b crst=%b expected 1/0", boot_done, core_reset); end
    cmpCnt++; if (pulseCnt !== p0) begin errCnt++; $display("FAIL zero_pulses: got %0d expected %0d", pulseCnt, p0); end
  endtask

  task automatic test_len_overflow();
    pulseBootReq(1'b0, 8'h00);
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h01);
    cmpCnt++; if (boot_err !== 1'b1 || core_reset !== 1'b1) begin errCnt++; $display("FAIL ovf_err: got err=%b crst=%b expected 1/1", boot_err, core_reset); end
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
    cmpCnt++; if (boot_err !== 1'b1 || boot_done !== 1'b0) begin errCnt++; $display("FAIL ovf_sticky: got err=%b done=%b expected 1/0", boot_err, boot_done); end
    pulseBootReq(1'b0, 8'h00);
    cmpCnt++; if (boot_err !== 1'b0 || core_reset !== 1'b1) begin errCnt++; $display("FAIL ovf_clear: got err=%b crst=%b expected 0/1", boot_err, core_reset); end
  endtask

  task automatic test_abort_restart();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00); sendByte(8'h13); sendByte(8'h05);
    pulseBootReq(1'b1, 8'hA5);
    cmpCnt++; if (word_cnt !== 16'd0 || InstrWrite !== 1'b0) begin errCnt++; $display("FAIL abort_cnt: got %0d/%b expected 0/0", word_cnt, InstrWrite); end
    sendByte(8'h00); sendByte(8'h00);
    cmpCnt++; if (boot_done !== 1'b0 || boot_err !== 1'b0) begin errCnt++; $display("FAIL abort_magic_dropped: got done=%b err=%b expected 0/0", boot_done, boot_err); end
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'h13); sendByte(8'h05); sendByte(8'hA0); sendByte(8'h00);
    cmpCnt++; if (InstrWrite !== 1'b1 || WriteAdress !== 32'h0 || WriteInst !== 32'h00A00513) begin
      errCnt++; $display("FAIL restart_w0: got we=%b %h@%h expected 1 00a00513@00000000", InstrWrite, WriteInst, WriteAdress); end
    sendByte(8'h93); sendByte(8'h05); sendByte(8'hB0); sendByte(8'h00);
    cmpCnt++; if (InstrWrite !== 1'b1 || WriteAdress !== 32'h4 || WriteInst !== 32'h00B00593) begin
      errCnt++; $display("FAIL restart_w1: got we=%b %h@%h expected 1 00b00593@00000004", InstrWrite, WriteInst, WriteAdress); end
`ifdef IMEM_BOOT_CHECKSUM_EN
    sendByte(8'h92);
`else
    @(negedge clk);
`endif
    cmpCnt++; if (boot_done !== 1'b1) begin errCnt++; $display("FAIL restart_done: got %b expected 1", boot_done); end
  endtask

  task automatic test_max_words();
    int unsigned p0;
    int unsigned badWrites = 0;
    logic [31:0] w;
    logic [7:0]  x = 8'h01;
    pulseBootReq(1'b0, 8'h00);
    p0 = pulseCnt;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    for (int i = 0; i < 256; i++) begin
      w = {8'(i), 8'h3C, ~8'(i), 8'(i)};
      for (int b = 0; b < 4; b++) begin
        x = x ^ w[8*b +: 8];
        sendByte(w[8*b +: 8]);
      end
      if (InstrWrite !== 1'b1 || WriteInst !== w || WriteAdress !== 32'(i) * 32'd4) badWrites++;
    end
    cmpCnt++; if (badWrites !== 0) begin errCnt++; $display("FAIL max_writes: got %0d bad writes expected 0 (last %h@%h)", badWrites, WriteInst, WriteAdress); end
    cmpCnt++; if (WriteAdress !== 32'h3FC) begin errCnt++; $display("FAIL max_last_addr: got %h expected 000003fc", WriteAdress); end
`ifdef IMEM_BOOT_CHECKSUM_EN
    sendByte(x);
`else
    @(negedge clk);
`endif
    cmpCnt++; if (boot_done !== 1'b1 || word_cnt !== 16'd256) begin errCnt++; $display("FAIL max_done: got done=%b cnt=%0d expected 1/256", boot_done, word_cnt); end
    cmpCnt++; if (pulseCnt - p0 !== 256) begin errCnt++; $display("FAIL max_pulses: got %0d expected 256", pulseCnt - p0); end
  endtask

  task automatic test_midload_reset();
    pulseBootReq(1'b0, 8'h00);
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h00); sendByte(8'h13);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmpCnt++; if (core_reset !== 1'b1 || InstrWrite !== 1'b0 || word_cnt !== 16'd0 || WriteAdress !== 32'h0) begin
      errCnt++; $display("FAIL midreset_vals: got crst=%b we=%b cnt=%0d addr=%h expected 1/0/0/00000000", core_reset, InstrWrite, word_cnt, WriteAdress); end
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44);
    cmpCnt++; if (InstrWrite !== 1'b1 || WriteInst !== 32'h44332211 || WriteAdress !== 32'h0) begin
      errCnt++; $display("FAIL midreset_reload: got we=%b %h@%h expected 1 44332211@00000000", InstrWrite, WriteInst, WriteAdress); end
`ifdef IMEM_BOOT_CHECKSUM_EN
    sendByte(8'h01 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`else
    @(negedge clk);
`endif
    cmpCnt++; if (boot_done !== 1'b1) begin errCnt++; $display("FAIL midreset_done: got %b expected 1", boot_done); end
  endtask

`ifdef IMEM_BOOT_CHECKSUM_EN
  task automatic test_checksum_bad();
    pulseBootReq(1'b0, 8'h00);
    sendTwoWordFrame();
    sendByte(8'h93);
    cmpCnt++; if (boot_err !== 1'b1 || core_reset !== 1'b1 || boot_done !== 1'b0) begin
      errCnt++; $display("FAIL chk_bad: got err=%b crst=%b done=%b expected 1/1/0", boot_err, core_reset, boot_done); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    boot_req = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_word();
    test_zero_len();
    test_len_overflow();
    test_abort_restart();
    test_max_words();
    test_midload_reset();
`ifdef IMEM_BOOT_CHECKSUM_EN
    test_checksum_bad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule
